// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: FIFO-fed, first start bit one cycle after accept into an idle, empty buffer.
// data_out_ready drops while the buffer is full and stays low even on a cycle that pops.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE       = 31_250,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clock_50_000_000,
  input  logic       reset,
  input  logic [7:0] data_out,
  input  logic       data_out_valid,
  output logic       data_out_ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int unsigned CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CNT_W  = (CLOCKS_PER_BIT < 2) ? 1 : $clog2(CLOCKS_PER_BIT);
  localparam int unsigned PTR_W  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  if (CLOCKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift_reg, shift_nxt;
  logic              tx_nxt;
  logic              bit_end;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count, count_nxt;
  logic              full, empty, push, pop;

  assign full           = (count == FCNT_W'(FIFO_DEPTH));
  assign empty          = (count == '0);
  assign data_out_ready = !full;
  assign push           = data_out_valid && !full && !reset;
  assign bit_end        = (bit_cnt == CNT_W'(CLOCKS_PER_BIT - 1));

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          bit_cnt_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is computed from the next state so uart_tx is a clean flop output.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[bit_idx_nxt];
      default: tx_nxt = 1'b1;
    endcase

    case ({push, pop})
      2'b10:   count_nxt = count + FCNT_W'(1);
      2'b01:   count_nxt = count - FCNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
      uart_tx   <= tx_nxt;
      busy      <= (state_nxt != IDLE) || (count_nxt != '0);
      count     <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (push) mem[wr_ptr] <= data_out;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 16 clocks per bit (160 Hz clock, 10 bit/s), FIFO_DEPTH 4.
module tb_uart_transmitter;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_out = 8'h00;
  logic       data_out_valid = 1'b0;
  logic       data_out_ready;
  logic       uart_tx;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  uart_transmitter #(
    .CLOCK_FREQUENCY(160),
    .BAUD_RATE(10),
    .FIFO_DEPTH(4)
  ) dut (
    .clock_50_000_000(clk),
    .reset(reset),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .uart_tx(uart_tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures one frame starting at the first cycle of its start bit; each bit must be steady for CPB cycles.
  task automatic rx_frame(output logic [7:0] d, output logic ok, output logic busy_hi);
    logic first;
    d = 8'h00;
    ok = 1'b1;
    busy_hi = 1'b1;
    for (int b = 0; b < 10; b++) begin
      first = uart_tx;
      for (int c = 0; c < CPB; c++) begin
        if (uart_tx !== first) ok = 1'b0;
        if (busy !== 1'b1) busy_hi = 1'b0;
        tick();
      end
      if (b == 0 && first !== 1'b0) ok = 1'b0;
      if (b == 9 && first !== 1'b1) ok = 1'b0;
      if (b >= 1 && b <= 8) d[b-1] = first;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_out_valid = 1'b1;
    data_out = 8'hFF;
    tick();
    tick();
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (data_out_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", data_out_ready); end
    reset = 1'b0;
    data_out_valid = 1'b0;
    repeat (3) tick();
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_no_accept_tx: got %b want 1", uart_tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic ok, bh;
    data_out = 8'h90;
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    data_out = 8'h00;
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_at_accept: got %b want 1", uart_tx); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_at_accept: got %b want 1", busy); end
    vectors++; if (data_out_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", data_out_ready); end
    tick();
    rx_frame(d, ok, bh);
    vectors++; if (d !== 8'h90) begin miscompares++; $display("FAIL single_data: got %h want 90", d); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_framing: got %b want 1", ok); end
    vectors++; if (bh !== 1'b1) begin miscompares++; $display("FAIL single_busy_during: got %b want 1", bh); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b want 0", busy); end
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL single_idle_tx: got %b want 1", uart_tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    logic [7:0] rx [3];
    logic       okv [3];
    logic       bhv [3];
    exp[0] = 8'h90; exp[1] = 8'h3C; exp[2] = 8'h7F;
    data_out = exp[0];
    data_out_valid = 1'b1;
    tick();
    data_out = exp[1];
    fork
      begin
        tick();
        data_out = exp[2];
        tick();
        data_out_valid = 1'b0;
        data_out = 8'hEE;
      end
      begin
        tick();
        for (int i = 0; i < 3; i++) rx_frame(rx[i], okv[i], bhv[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      vectors++; if (rx[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_data%0d: got %h want %h", i, rx[i], exp[i]); end
      vectors++; if (okv[i] !== 1'b1 || bhv[i] !== 1'b1) begin miscompares++; $display("FAIL b2b_frame%0d: framing %b busy %b want 1 1", i, okv[i], bhv[i]); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_full();
    logic [7:0] exp [6];
    logic [7:0] rx [6];
    logic       okv [6];
    logic       bhv [6];
    int         waited;
    for (int i = 0; i < 6; i++) exp[i] = 8'hA1 + 8'(i);
    data_out = exp[0];
    data_out_valid = 1'b1;
    tick();
    waited = 0;
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          data_out = exp[i];
          tick();
        end
        vectors++; if (data_out_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_low: got %b want 0", data_out_ready); end
        data_out = exp[5];
        while (data_out_ready !== 1'b1 && waited < 400) begin
          tick();
          waited++;
        end
        tick();
        data_out_valid = 1'b0;
        data_out = 8'h00;
        vectors++; if (data_out_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_refill: got %b want 0", data_out_ready); end
      end
      begin
        tick();
        for (int i = 0; i < 6; i++) rx_frame(rx[i], okv[i], bhv[i]);
      end
    join
    vectors++; if (waited != 157) begin miscompares++; $display("FAIL full_hold_cycles: got %0d want 157", waited); end
    for (int i = 0; i < 6; i++) begin
      vectors++; if (rx[i] !== exp[i] || okv[i] !== 1'b1) begin miscompares++; $display("FAIL full_frame%0d: got %h framing %b want %h framing 1", i, rx[i], okv[i], exp[i]); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp [3];
    logic [7:0] rx [3];
    logic       okv [3];
    logic       bhv [3];
    exp[0] = 8'h5A; exp[1] = 8'hC3; exp[2] = 8'h0F;
    data_out = exp[0];
    data_out_valid = 1'b1;
    tick();
    data_out = exp[1];
    fork
      begin
        tick();
        data_out_valid = 1'b0;
        data_out = 8'h00;
        repeat (159) tick();
        vectors++; if (data_out_ready !== 1'b1) begin miscompares++; $display("FAIL pp_ready_before: got %b want 1", data_out_ready); end
        data_out = exp[2];
        data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        data_out = 8'hFF;
      end
      begin
        tick();
        for (int i = 0; i < 3; i++) rx_frame(rx[i], okv[i], bhv[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      vectors++; if (rx[i] !== exp[i] || okv[i] !== 1'b1 || bhv[i] !== 1'b1) begin miscompares++; $display("FAIL pp_frame%0d: got %h framing %b busy %b want %h 1 1", i, rx[i], okv[i], bhv[i], exp[i]); end
    end
    vectors++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin miscompares++; $display("FAIL pp_idle_after: busy %b tx %b want 0 1", busy, uart_tx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic ok, bh;
    logic quiet;
    data_out = 8'hA5;
    data_out_valid = 1'b1;
    tick();
    data_out = 8'h11;
    tick();
    data_out = 8'h22;
    tick();
    data_out_valid = 1'b0;
    repeat (68) tick();
    // Inside data bit 3 of 0xA5, which is 0.
    vectors++; if (uart_tx !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_bit3: tx %b busy %b want 0 1", uart_tx, busy); end
    reset = 1'b1;
    tick();
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx: got %b want 1", uart_tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vectors++; if (data_out_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", data_out_ready); end
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (uart_tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    vectors++; if (quiet !== 1'b1) begin miscompares++; $display("FAIL rst_mid_discard: got %b want 1", quiet); end
    data_out = 8'h55;
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    data_out = 8'hAA;
    tick();
    rx_frame(d, ok, bh);
    vectors++; if (d !== 8'h55 || ok !== 1'b1) begin miscompares++; $display("FAIL rst_mid_after: got %h framing %b want 55 1", d, ok); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_after_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
